lut_arbiter: RTL and testbench
==============================

LUT_ARBITER -- requirements
Module: lut_arbiter

Interface
REQ-001 Parameter NR_REQ, default 4: number of lookup requesters (2..8).
REQ-002 Parameter NR_KEY, default 4: number of programmable table entries.
REQ-003 Parameter KEY_LEN, default 4: key width in bits.
REQ-004 Parameter DATA_LEN, default 8: data width in bits; IDX_LEN = $clog2(NR_KEY), ID_LEN = $clog2(NR_REQ).
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 cfg_we  input  1  table write strobe.
REQ-008 cfg_idx  input  IDX_LEN  entry written.
REQ-009 cfg_en  input  1  written entry's valid bit.
REQ-010 cfg_key / cfg_data  input  KEY_LEN / DATA_LEN  written key and data.
REQ-011 default_out  input  DATA_LEN  data returned on miss.
REQ-012 req_valid  input  NR_REQ  per-requester request.
REQ-013 req_key  input  NR_REQ*KEY_LEN  requester i key at bits [KEY_LEN*(i+1)-1 : KEY_LEN*i].
REQ-014 req_ready  output  NR_REQ  per-requester accept, one-hot or zero.
REQ-015 rsp_valid / rsp_ready  output / input  1  shared response handshake.
REQ-016 rsp_id / rsp_data / rsp_hit  output  ID_LEN / DATA_LEN / 1  response owner, data, hit flag.
REQ-017 stat_hits / stat_misses  output  16 / 16  lookup statistics (see Configuration).

Function
REQ-018 Table: NR_KEY registered entries {valid, key, data}; on rising clk with cfg_we=1 and cfg_idx<NR_KEY, entry cfg_idx takes {cfg_en, cfg_key, cfg_data}; cfg_idx>=NR_KEY ignored.
REQ-019 Lookup: hit when any valid entry key equals the key; on multiple hits the lowest-index entry's data wins; miss returns default_out.
REQ-020 Advance condition: adv = !cfg_we && (!rsp_valid || rsp_ready).
REQ-021 Arbitration: round-robin; search starts at last_grant+1 modulo NR_REQ; first requester with req_valid=1 is granted; req_ready[g]=adv for granted g, all other bits 0; combinational from inputs.
REQ-022 last_grant updates to g only on transfer (req_valid[g] && req_ready[g]); unaccepted requests do not move the pointer.
REQ-023 Latency: on transfer in cycle N, rsp_valid=1 in cycle N+1 with rsp_id=g, rsp_data/rsp_hit from the table contents at edge N (a write in cycle N cannot coexist, per REQ-020).
REQ-024 Response held stable while rsp_valid && !rsp_ready; cleared after rsp_ready unless a new transfer occurs same cycle (back-to-back: one response per cycle).
REQ-025 cfg_we has strict priority: no grant in a write cycle; a write in cycle N is visible to lookups transferred in cycle N+1.
REQ-026 Requests are non-blocking: a requester may drop req_valid without transfer.

Reset
REQ-027 rst_n=0 asynchronously: all entry valid bits 0 (key/data 0), last_grant=NR_REQ-1 (requester 0 first), rsp_valid=0, rsp_id=0, rsp_data=0, rsp_hit=0, stat counters 0.
REQ-028 Reset mid-operation discards any pending response; no response emitted for it after release.
REQ-029 First grant possible in first cycle with rst_n=1.

Configuration
REQ-030 Macro LUT_ARBITER_STATS_EN defined: stat_hits/stat_misses increment by 1 per transfer that hits/misses, saturating at 16'hFFFF.
REQ-031 Macro undefined: no counters synthesised; stat_hits and stat_misses tied to 0.

Verification
REQ-032 Reset, no writes, req_valid=4'b0001, key=3, default_out=8'hAA -> next cycle rsp_valid=1, rsp_id=0, rsp_hit=0, rsp_data=8'hAA.
REQ-033 Write idx0 {en=1,key=3,data=8'h11} and idx2 {en=1,key=3,data=8'h22}; lookup key 3 -> rsp_hit=1, rsp_data=8'h11; rewrite idx0 en=0 -> rsp_data=8'h22.
REQ-034 req_valid=4'b1111 held, rsp_ready=1 -> grants 0,1,2,3,0 in consecutive cycles, one response per cycle.
REQ-035 rsp_ready=0 for 3 cycles with req_valid=4'b0110 -> response for id 1 held stable, req_ready=0; rsp_ready=1 -> id 2 granted same cycle, response next.
REQ-036 cfg_we=1 in same cycle as req_valid=4'b0001 -> req_ready=0 that cycle; grant next cycle returns newly written data.
REQ-037 With LUT_ARBITER_STATS_EN: 2 hits, 3 misses -> stat_hits=2, stat_misses=3; rst_n pulse mid-response -> rsp_valid=0 and counters 0 immediately.

Source files
------------

// File: rtl/lut_arbiter.sv
// lut_arbiter: round-robin arbiter in front of a small programmable
// key/data lookup table with a single registered response slot.
// Optional feature: define LUT_ARBITER_STATS_EN to build saturating
// hit/miss counters; otherwise stat_hits/stat_misses read as zero.
module lut_arbiter #(
  parameter int NR_REQ   = 4,
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 4,
  parameter int DATA_LEN = 8,
  parameter int IDX_LEN  = (NR_KEY > 1) ? $clog2(NR_KEY) : 1,
  parameter int ID_LEN   = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_we,
  input  logic [IDX_LEN-1:0]        cfg_idx,
  input  logic                      cfg_en,
  input  logic [KEY_LEN-1:0]        cfg_key,
  input  logic [DATA_LEN-1:0]       cfg_data,
  input  logic [DATA_LEN-1:0]       default_out,
  input  logic [NR_REQ-1:0]         req_valid,
  input  logic [NR_REQ*KEY_LEN-1:0] req_key,
  output logic [NR_REQ-1:0]         req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_LEN-1:0]         rsp_id,
  output logic [DATA_LEN-1:0]       rsp_data,
  output logic                      rsp_hit,
  output logic [15:0]               stat_hits,
  output logic [15:0]               stat_misses
);

  typedef enum logic {
    RSP_IDLE,
    RSP_FULL
  } rsp_state_t;

  rsp_state_t state, state_next;

  logic [NR_KEY-1:0]   ent_valid;
  logic [KEY_LEN-1:0]  ent_key  [NR_KEY];
  logic [DATA_LEN-1:0] ent_data [NR_KEY];

  logic [ID_LEN-1:0]   last_grant;
  logic [ID_LEN-1:0]   grant_idx;
  logic                grant_found;
  int unsigned         cand;
  logic                adv;
  logic                xfer;

  logic [KEY_LEN-1:0]  sel_key;
  logic                lookup_hit;
  logic [DATA_LEN-1:0] lookup_data;

  // Table programming; out-of-range indices are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid <= '0;
      for (int unsigned i = 0; i < NR_KEY; i++) begin
        ent_key[i]  <= '0;
        ent_data[i] <= '0;
      end
    end else if (cfg_we && (32'(cfg_idx) < 32'(NR_KEY))) begin
      ent_valid[cfg_idx] <= cfg_en;
      ent_key[cfg_idx]   <= cfg_key;
      ent_data[cfg_idx]  <= cfg_data;
    end
  end

  // Round-robin search starting one past the last accepted requester.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int unsigned k = 1; k <= NR_REQ; k++) begin
      cand = (32'(last_grant) + k) % 32'(NR_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = ID_LEN'(cand);
      end
    end
  end

  // Table writes and a stalled response both block acceptance.
  always_comb begin
    adv       = !cfg_we && ((state == RSP_IDLE) || rsp_ready);
    xfer      = adv && grant_found;
    req_ready = '0;
    if (xfer) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Lookup of the granted key; lowest matching valid entry wins.
  always_comb begin
    sel_key     = req_key[32'(grant_idx)*KEY_LEN +: KEY_LEN];
    lookup_hit  = 1'b0;
    lookup_data = default_out;
    for (int unsigned i = 0; i < NR_KEY; i++) begin
      if (!lookup_hit && ent_valid[i] && (ent_key[i] == sel_key)) begin
        lookup_hit  = 1'b1;
        lookup_data = ent_data[i];
      end
    end
  end

  // Round-robin pointer moves only on an accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= ID_LEN'(NR_REQ - 1);
    end else if (xfer) begin
      last_grant <= grant_idx;
    end
  end

  // Response slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RSP_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Response slot fills on transfer, drains on rsp_ready, holds otherwise.
  always_comb begin
    state_next = state;
    if (xfer) begin
      state_next = RSP_FULL;
    end else if (rsp_ready) begin
      state_next = RSP_IDLE;
    end
  end

  // Response payload captured from the lookup at the transfer edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id   <= '0;
      rsp_data <= '0;
      rsp_hit  <= 1'b0;
    end else if (xfer) begin
      rsp_id   <= grant_idx;
      rsp_data <= lookup_data;
      rsp_hit  <= lookup_hit;
    end
  end

  assign rsp_valid = (state == RSP_FULL);

`ifdef LUT_ARBITER_STATS_EN
  logic [15:0] hits_q;
  logic [15:0] misses_q;

  // Saturating per-transfer hit/miss counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else if (xfer) begin
      if (lookup_hit) begin
        if (hits_q != '1) hits_q <= hits_q + 16'd1;
      end else begin
        if (misses_q != '1) misses_q <= misses_q + 16'd1;
      end
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`else
  assign stat_hits   = '0;
  assign stat_misses = '0;
`endif

endmodule

// File: tb/tb_lut_arbiter.sv
// Bench for lut_arbiter: table-driven vectors plus hand sequences for
// backpressure, write priority and asynchronous reset. Responses are
// checked through a scoreboard queue filled when a transfer is expected.
module tb_lut_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic        cfg_en;
  logic [3:0]  cfg_key;
  logic [7:0]  cfg_data;
  logic [7:0]  default_out;
  logic [3:0]  req_valid;
  logic [15:0] req_key;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        rsp_hit;
  logic [15:0] stat_hits;
  logic [15:0] stat_misses;

  lut_arbiter #(
    .NR_REQ  (4),
    .NR_KEY  (4),
    .KEY_LEN (4),
    .DATA_LEN(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_en     (cfg_en),
    .cfg_key    (cfg_key),
    .cfg_data   (cfg_data),
    .default_out(default_out),
    .req_valid  (req_valid),
    .req_key    (req_key),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_hit    (rsp_hit),
    .stat_hits  (stat_hits),
    .stat_misses(stat_misses)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  idx;
    logic        en;
    logic [3:0]  ckey;
    logic [7:0]  cdata;
    logic [3:0]  rv;
    logic [15:0] rk;
    logic        rr;
    logic [7:0]  dflt;
    logic [3:0]  exp_ready;
    logic        exp_hit;
    logic [7:0]  exp_data;
  } vec_t;

  typedef struct {
    logic [1:0] id;
    logic       hit;
    logic [7:0] data;
  } rsp_t;

  rsp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_hits   = 0;
  int   n_miss   = 0;
  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] idx, input logic en,
                              input logic [3:0] ck, input logic [7:0] cd,
                              input logic [3:0] rv, input logic [15:0] rk, input logic rr,
                              input logic [7:0] df, input logic [3:0] er,
                              input logic eh, input logic [7:0] ed);
    vec_t v;
    v.we = we; v.idx = idx; v.en = en; v.ckey = ck; v.cdata = cd;
    v.rv = rv; v.rk = rk; v.rr = rr; v.dflt = df;
    v.exp_ready = er; v.exp_hit = eh; v.exp_data = ed;
    return v;
  endfunction

  function automatic vec_t idle_vec();
    return mk(0, 0, 0, 4'h0, 8'h00, 4'b0000, 16'h0000, 1, 8'hAA, 4'b0000, 0, 8'h00);
  endfunction

  task automatic check_stats();
`ifdef LUT_ARBITER_STATS_EN
    chk("stat_hits", 32'(stat_hits), 32'(n_hits));
    chk("stat_misses", 32'(stat_misses), 32'(n_miss));
`else
    chk("stat_hits_tied", 32'(stat_hits), 32'd0);
    chk("stat_misses_tied", 32'(stat_misses), 32'd0);
`endif
  endtask

  // Called at a falling edge: drive, check, advance one cycle.
  task automatic step(input vec_t v);
    rsp_t r;
    cfg_we      = v.we;
    cfg_idx     = v.idx;
    cfg_en      = v.en;
    cfg_key     = v.ckey;
    cfg_data    = v.cdata;
    req_valid   = v.rv;
    req_key     = v.rk;
    rsp_ready   = v.rr;
    default_out = v.dflt;
    #1;
    chk("req_ready", 32'(req_ready), 32'(v.exp_ready));
    if (q.size() > 0) begin
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
      chk("rsp_data", 32'(rsp_data), 32'(q[0].data));
      chk("rsp_hit", 32'(rsp_hit), 32'(q[0].hit));
    end else begin
      chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
    end
    check_stats();
    @(posedge clk);
    if (q.size() > 0 && v.rr) void'(q.pop_front());
    if (v.exp_ready != 4'b0000) begin
      r.id = 2'd0;
      for (int i = 0; i < 4; i++) if (v.exp_ready[i]) r.id = 2'(i);
      r.hit  = v.exp_hit;
      r.data = v.exp_data;
      q.push_back(r);
      if (v.exp_hit) n_hits++;
      else n_miss++;
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //           we idx en ck    cd     rv       rk        rr df     exp_rdy  hit data
    tbl[0]  = mk(0, 0, 0, 4'h0, 8'h00, 4'b0001, 16'h0003, 1, 8'hAA, 4'b0001, 0, 8'hAA);
    tbl[1]  = mk(1, 0, 1, 4'h3, 8'h11, 4'b0001, 16'h0003, 1, 8'hAA, 4'b0000, 0, 8'h00);
    tbl[2]  = mk(1, 2, 1, 4'h3, 8'h22, 4'b0000, 16'h0000, 1, 8'hAA, 4'b0000, 0, 8'h00);
    tbl[3]  = mk(0, 0, 0, 4'h0, 8'h00, 4'b0001, 16'h0003, 1, 8'hAA, 4'b0001, 1, 8'h11);
    tbl[4]  = mk(1, 0, 0, 4'h3, 8'h11, 4'b0010, 16'h0030, 1, 8'hAA, 4'b0000, 0, 8'h00);
    tbl[5]  = mk(0, 0, 0, 4'h0, 8'h00, 4'b0010, 16'h0030, 1, 8'hAA, 4'b0010, 1, 8'h22);
    tbl[6]  = mk(1, 1, 1, 4'h5, 8'h55, 4'b0000, 16'h0000, 1, 8'hAA, 4'b0000, 0, 8'h00);
    tbl[7]  = mk(1, 3, 1, 4'h5, 8'h66, 4'b0000, 16'h0000, 1, 8'hAA, 4'b0000, 0, 8'h00);
    tbl[8]  = mk(0, 0, 0, 4'h0, 8'h00, 4'b1111, 16'h5735, 1, 8'hAA, 4'b0100, 0, 8'hAA);
    tbl[9]  = mk(0, 0, 0, 4'h0, 8'h00, 4'b1111, 16'h5735, 1, 8'hAA, 4'b1000, 1, 8'h55);
    tbl[10] = mk(0, 0, 0, 4'h0, 8'h00, 4'b1111, 16'h5735, 1, 8'hAA, 4'b0001, 1, 8'h55);
    tbl[11] = mk(0, 0, 0, 4'h0, 8'h00, 4'b1111, 16'h5735, 1, 8'hAA, 4'b0010, 1, 8'h22);
    tbl[12] = mk(0, 0, 0, 4'h0, 8'h00, 4'b1111, 16'h5735, 1, 8'hAA, 4'b0100, 0, 8'hAA);
    tbl[13] = mk(0, 0, 0, 4'h0, 8'h00, 4'b0000, 16'h0000, 1, 8'hAA, 4'b0000, 0, 8'h00);
    tbl[14] = mk(0, 0, 0, 4'h0, 8'h00, 4'b0100, 16'h0900, 1, 8'h3C, 4'b0100, 0, 8'h3C);

    rst_n       = 1'b0;
    cfg_we      = 1'b0;
    cfg_idx     = '0;
    cfg_en      = 1'b0;
    cfg_key     = '0;
    cfg_data    = '0;
    default_out = 8'hAA;
    req_valid   = '0;
    req_key     = '0;
    rsp_ready   = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_rsp_hit", 32'(rsp_hit), 32'd0);
    check_stats();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) step(tbl[i]);
    step(idle_vec());

    // Backpressure: id 1 held for three stalled cycles, then id 2 granted.
    step(mk(0, 0, 0, 4'h0, 8'h00, 4'b0110, 16'h0530, 0, 8'hAA, 4'b0010, 1, 8'h22));
    for (int i = 0; i < 3; i++)
      step(mk(0, 0, 0, 4'h0, 8'h00, 4'b0110, 16'h0530, 0, 8'hAA, 4'b0000, 0, 8'h00));
    step(mk(0, 0, 0, 4'h0, 8'h00, 4'b0110, 16'h0530, 1, 8'hAA, 4'b0100, 1, 8'h55));
    step(idle_vec());
    step(idle_vec());

    // Write priority: no grant while writing, new data seen next cycle.
    step(mk(1, 0, 1, 4'h3, 8'h77, 4'b0001, 16'h0003, 1, 8'hAA, 4'b0000, 0, 8'h00));
    step(mk(0, 0, 0, 4'h0, 8'h00, 4'b0001, 16'h0003, 1, 8'hAA, 4'b0001, 1, 8'h77));
    step(idle_vec());

    // Asynchronous reset while a stalled response is pending.
    step(mk(0, 0, 0, 4'h0, 8'h00, 4'b0001, 16'h0003, 0, 8'hAA, 4'b0001, 1, 8'h77));
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midreset_rsp_data", 32'(rsp_data), 32'd0);
    chk("midreset_rsp_hit", 32'(rsp_hit), 32'd0);
    q.delete();
    n_hits = 0;
    n_miss = 0;
    check_stats();
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step(idle_vec());

    // After reset: table empty, pointer restarts at requester 0.
    step(mk(0, 0, 0, 4'h0, 8'h00, 4'b1111, 16'h3333, 1, 8'hAA, 4'b0001, 0, 8'hAA));
    step(mk(0, 0, 0, 4'h0, 8'h00, 4'b1111, 16'h3333, 1, 8'hAA, 4'b0010, 0, 8'hAA));
    step(mk(0, 0, 0, 4'h0, 8'h00, 4'b1111, 16'h3333, 1, 8'hAA, 4'b0100, 0, 8'hAA));
    step(mk(0, 0, 0, 4'h0, 8'h00, 4'b1111, 16'h3333, 1, 8'hAA, 4'b1000, 0, 8'hAA));
    step(mk(0, 0, 0, 4'h0, 8'h00, 4'b1111, 16'h3333, 1, 8'hAA, 4'b0001, 0, 8'hAA));
    step(idle_vec());
    step(idle_vec());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
